// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus: next-PC in, current PC / instruction word / end-of-program out.
// The fetch stage uses the slave modport; next-PC logic and decoder use master.
interface busca_instrucao_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] entrada;
   logic [ADDR_W-1:0] endereco;
   logic [DATA_W-1:0] instrucao;
   logic              fim;

   modport master (output entrada, input endereco, input instrucao, input fim);
   modport slave  (input entrada, output endereco, output instrucao, output fim);
endinterface

// File: rtl/busca_instrucao.sv
// Redux-V instruction fetch: PC register feeding a combinational-read ROM.
// The ROM image is a packed parameter; word i sits at bits [i*DATA_W +: DATA_W].

module contador_de_programa #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] entrada,
   output logic [ADDR_W-1:0] saida
);
   // No enable and no increment: next-PC logic owns hold and wrap-around.
   always_ff @(posedge clk) begin
      if (rst) saida <= '0;
      else     saida <= entrada;
   end
endmodule

module memoria_instrucoes #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int PROG_LEN = 100,
   parameter logic [DATA_W*(2**ADDR_W)-1:0] PROG_IMAGE = '0
) (
   input  logic [ADDR_W-1:0] endereco,
   output logic [DATA_W-1:0] instrucao
);
   localparam logic [ADDR_W:0] LEN_C = PROG_LEN[ADDR_W:0];

   // Anything past the program reads as zero regardless of image contents.
   always_comb begin
      instrucao = '0;
      if ({1'b0, endereco} < LEN_C)
         instrucao = PROG_IMAGE[int'(endereco)*DATA_W +: DATA_W];
   end
endmodule

module busca_instrucao #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int PROG_LEN = 100,
   parameter logic [DATA_W*(2**ADDR_W)-1:0] PROG_IMAGE = '0
) (
   input  logic              clk,
   input  logic              rst,
   busca_instrucao_if.slave  bus
);
   localparam logic [ADDR_W:0] LEN_C = PROG_LEN[ADDR_W:0];

   logic [ADDR_W-1:0] pc;

   contador_de_programa #(
      .ADDR_W (ADDR_W)
   ) u_pc (
      .clk     (clk),
      .rst     (rst),
      .entrada (bus.entrada),
      .saida   (pc)
   );

   memoria_instrucoes #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .PROG_LEN   (PROG_LEN),
      .PROG_IMAGE (PROG_IMAGE)
   ) u_rom (
      .endereco  (pc),
      .instrucao (bus.instrucao)
   );

   assign bus.endereco = pc;
   assign bus.fim      = ({1'b0, pc} >= LEN_C);
endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: table of single-cycle vectors plus
// hand-written sequential-fetch and between-edge reset sequences.
module tb_busca_instrucao;
   typedef struct {
      logic       rst;
      logic [7:0] entrada;
      logic [7:0] exp_end;
      logic [7:0] exp_instr;
      logic       exp_fim;
   } vec_t;

   // Program words are i ^ A5; words past the program hold EE so forcing to 00 is visible.
   function automatic logic [2047:0] make_img();
      logic [2047:0] img;
      img = '0;
      for (int i = 0; i < 256; i++)
         img[i*8 +: 8] = (i < 100) ? (8'(i) ^ 8'hA5) : 8'hEE;
      return img;
   endfunction

   localparam logic [2047:0] IMG = make_img();

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   busca_instrucao_if bus ();

   busca_instrucao #(
      .DATA_W     (8),
      .ADDR_W     (8),
      .PROG_LEN   (100),
      .PROG_IMAGE (IMG)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [7:0] e);
      @(negedge clk);
      rst         = r;
      bus.entrada = e;
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];
   logic [7:0] prev;

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.entrada = 8'h00;

      // rst, entrada -> endereco, instrucao, fim
      vecs.push_back('{1'b1, 8'h37, 8'h00, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'd100, 8'd100, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 8'd101, 8'd101, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 8'd99, 8'd99, 8'hC6, 1'b0});
      vecs.push_back('{1'b0, 8'hFF, 8'hFF, 8'h00, 1'b1});
      vecs.push_back('{1'b0, 8'h00, 8'h00, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'd42, 8'd42, 8'h8F, 1'b0});
      vecs.push_back('{1'b1, 8'd43, 8'h00, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 8'd43, 8'd43, 8'h8E, 1'b0});
      vecs.push_back('{1'b0, 8'd43, 8'd43, 8'h8E, 1'b0});
      vecs.push_back('{1'b1, 8'hC0, 8'h00, 8'hA5, 1'b0});

      foreach (vecs[k]) begin
         step(vecs[k].rst, vecs[k].entrada);
         check($sformatf("vec%0d endereco", k), 32'(bus.endereco), 32'(vecs[k].exp_end));
         check($sformatf("vec%0d instrucao", k), 32'(bus.instrucao), 32'(vecs[k].exp_instr));
         check($sformatf("vec%0d fim", k), 32'(bus.fim), 32'(vecs[k].exp_fim));
      end

      // Sequential fetch through the whole program.
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 8'(i));
         check($sformatf("seq%0d endereco", i), 32'(bus.endereco), i);
         check($sformatf("seq%0d instrucao", i), 32'(bus.instrucao), 32'(8'(i) ^ 8'hA5));
         check($sformatf("seq%0d fim", i), 32'(bus.fim), 32'd0);
      end

      // Reset pulsed and released entirely between edges has no effect.
      prev        = bus.endereco;
      bus.entrada = 8'h50;
      #2 rst = 1'b1;
      #1 check("midcycle rst high endereco", 32'(bus.endereco), 32'(prev));
      #1 rst = 1'b0;
      #1 check("midcycle rst low endereco", 32'(bus.endereco), 32'(prev));
      @(posedge clk);
      #1 check("after glitch endereco", 32'(bus.endereco), 32'h50);
      check("after glitch instrucao", 32'(bus.instrucao), 32'(8'h50 ^ 8'hA5));

      // Reset raised between edges only takes effect at the next edge.
      bus.entrada = 8'h51;
      #2 rst = 1'b1;
      #1 check("rst pending endereco", 32'(bus.endereco), 32'h50);
      @(posedge clk);
      #1 check("rst taken endereco", 32'(bus.endereco), 32'h00);
      check("rst taken instrucao", 32'(bus.instrucao), 32'hA5);
      step(1'b0, 8'h51);
      check("post rst endereco", 32'(bus.endereco), 32'h51);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
